// File: rtl/sha_pkg.sv
// Shared SHA constants, the block-loader state encoding and a word byte-reversal helper.
package sha_pkg;

    localparam int SHA_WORD_W       = 32;
    localparam int SHA_BLK416_WORDS = 13;

    typedef enum logic {
        FILL   = 1'b0,
        COMMIT = 1'b1
    } loader_state_t;

    function automatic logic [SHA_WORD_W-1:0] byte_swap32(input logic [SHA_WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/sha_block_loader_416.sv
// Packs 13 handshaked 32-bit words MSB-first into a 416-bit block and strobes it into the block memory.
// Define SHA_LOADER_BYTE_SWAP_EN to byte-reverse every incoming word (little-endian hosts).
module sha_block_loader_416
    import sha_pkg::*;
#(
    parameter int WORD_W    = SHA_WORD_W,
    parameter int NUM_WORDS = SHA_BLK416_WORDS,
    parameter int BLOCK_W   = WORD_W * NUM_WORDS,
    parameter int CNT_W     = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_last,
    input  logic               flush,
    input  logic               dst_busy,
    output logic               write_en,
    output logic [BLOCK_W-1:0] block_out,
    output logic [CNT_W-1:0]   blk_count,
    output logic               err_frame
);

    localparam int WCNT_W = $clog2(NUM_WORDS);
    localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(NUM_WORDS - 1);

    loader_state_t      state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLOCK_W-1:0] block_q;
    logic [WORD_W-1:0]  word_in;
    logic               xfer;
    logic               load;
    logic               commit;

`ifdef SHA_LOADER_BYTE_SWAP_EN
    assign word_in = byte_swap32(in_data);
`else
    assign word_in = in_data;
`endif

    assign in_ready = (state_q == FILL);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        commit  = 1'b0;
        // Flush beats both a same-cycle transfer and a pending commit.
        if (flush) begin
            state_d = FILL;
            wcnt_d  = '0;
            err_d   = 1'b0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (xfer) begin
                        load = 1'b1;
                        if ((wcnt_q == LAST_IDX) && in_last) begin
                            state_d = COMMIT;
                        end else if (in_last || (wcnt_q == LAST_IDX)) begin
                            err_d  = 1'b1;
                            wcnt_d = '0;
                        end else begin
                            wcnt_d = wcnt_q + WCNT_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    if (!dst_busy) begin
                        commit  = 1'b1;
                        cnt_d   = cnt_q + CNT_W'(1);
                        wcnt_d  = '0;
                        state_d = FILL;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    // Strobe is suppressed while reset is asserted so an interrupted commit never reaches memory.
    assign write_en = commit && !RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FILL;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < NUM_WORDS; k++) begin
                if (load && (wcnt_q == WCNT_W'(k))) begin
                    block_q[BLOCK_W-1-WORD_W*k -: WORD_W] <= word_in;
                end
            end
        end
    end

    assign block_out = block_q;
    assign blk_count = cnt_q;
    assign err_frame = err_q;

endmodule

// File: tb/tb_sha_block_loader_416.sv
// Directed self-checking bench for sha_block_loader_416 (plus a narrow-counter instance for wrap).
module tb_sha_block_loader_416;

    logic         CLK = 1'b0;
    logic         RST;
    logic         in_valid, in_last, flush, dst_busy;
    logic [31:0]  in_data;
    logic         in_ready, write_en, err_frame;
    logic [415:0] block_out;
    logic [15:0]  blk_count;
    logic         in_ready2, write_en2, err_frame2;
    logic [415:0] block_out2;
    logic [2:0]   blk_count2;

    int errors = 0;
    int checks = 0;
    int we_count = 0;
    int consec = 0;
    logic prev_we = 1'b0;
    logic [415:0] we_blk = '0;

    sha_block_loader_416 dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .flush(flush), .dst_busy(dst_busy),
        .write_en(write_en), .block_out(block_out), .blk_count(blk_count),
        .err_frame(err_frame)
    );

    sha_block_loader_416 #(.CNT_W(3)) dut_w (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .flush(flush), .dst_busy(dst_busy),
        .write_en(write_en2), .block_out(block_out2), .blk_count(blk_count2),
        .err_frame(err_frame2)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (write_en) begin
            we_count++;
            we_blk = block_out;
            if (prev_we) consec++;
        end
        prev_we = write_en;
    end

    function automatic logic [31:0] expw(input logic [31:0] w);
`ifdef SHA_LOADER_BYTE_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [415:0] mk_block(input logic [31:0] base);
        logic [415:0] b;
        b = '0;
        for (int k = 0; k < 13; k++) b[415-32*k -: 32] = expw(base + k);
        return b;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b required 1 within 50 cycles", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_block(input logic [31:0] base);
        for (int k = 0; k < 13; k++) send_word(base + k, k == 12);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b need 1", in_ready); end
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL rst_we: got %b need 0", write_en); end
        checks++; if (block_out !== 416'd0) begin errors++; $display("FAIL rst_block: got %h need 0", block_out); end
        checks++; if (blk_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d need 0", blk_count); end
        checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL rst_err: got %b need 0", err_frame); end
    endtask

    task automatic test_basic();
        int w0;
        w0 = we_count;
        send_block(32'h0);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_ready_low: got %b need 0", in_ready); end
        checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL basic_we: got %b need 1", write_en); end
        checks++; if (block_out[415:384] !== expw(32'h0)) begin errors++; $display("FAIL basic_word0: got %h need %h", block_out[415:384], expw(32'h0)); end
        checks++; if (block_out[31:0] !== expw(32'hC)) begin errors++; $display("FAIL basic_word12: got %h need %h", block_out[31:0], expw(32'hC)); end
        checks++; if (block_out !== mk_block(32'h0)) begin errors++; $display("FAIL basic_block: got %h need %h", block_out, mk_block(32'h0)); end
        tick();
        checks++; if (we_count !== w0 + 1) begin errors++; $display("FAIL basic_we_once: got %0d need %0d", we_count, w0 + 1); end
        checks++; if (blk_count !== 16'd1) begin errors++; $display("FAIL basic_count: got %0d need 1", blk_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %b need 1", in_ready); end
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL basic_we_drop: got %b need 0", write_en); end
    endtask

    task automatic test_backpressure();
        int w0;
        dst_busy = 1'b1;
        send_block(32'h100);
        w0 = we_count;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || write_en !== 1'b0) begin errors++; $display("FAIL bp_hold%0d: ready=%b we=%b need 0 0", i, in_ready, write_en); end
            checks++; if (block_out !== mk_block(32'h100)) begin errors++; $display("FAIL bp_block%0d: got %h need %h", i, block_out, mk_block(32'h100)); end
            tick();
        end
        dst_busy = 1'b0;
        #1;
        checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL bp_release_we: got %b need 1", write_en); end
        tick();
        checks++; if (blk_count !== 16'd2) begin errors++; $display("FAIL bp_count: got %0d need 2", blk_count); end
        checks++; if (we_count !== w0 + 1) begin errors++; $display("FAIL bp_we_once: got %0d need %0d", we_count, w0 + 1); end
        checks++; if (we_blk !== mk_block(32'h100)) begin errors++; $display("FAIL bp_we_block: got %h need %h", we_blk, mk_block(32'h100)); end
    endtask

    task automatic test_framing();
        int w0;
        w0 = we_count;
        for (int k = 0; k < 8; k++) send_word(32'h200 + k, k == 7);
        #1;
        checks++; if (err_frame !== 1'b1) begin errors++; $display("FAIL frm_early_err: got %b need 1", err_frame); end
        checks++; if (in_ready !== 1'b1 || write_en !== 1'b0) begin errors++; $display("FAIL frm_early_state: ready=%b we=%b need 1 0", in_ready, write_en); end
        send_block(32'h210);
        #1;
        checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL frm_recover_we: got %b need 1", write_en); end
        checks++; if (block_out !== mk_block(32'h210)) begin errors++; $display("FAIL frm_recover_block: got %h need %h", block_out, mk_block(32'h210)); end
        tick();
        checks++; if (blk_count !== 16'd3) begin errors++; $display("FAIL frm_recover_count: got %0d need 3", blk_count); end
        checks++; if (we_count !== w0 + 1) begin errors++; $display("FAIL frm_recover_once: got %0d need %0d", we_count, w0 + 1); end
        w0 = we_count;
        for (int k = 0; k < 13; k++) send_word(32'h220 + k, 1'b0);
        #1;
        checks++; if (in_ready !== 1'b1 || err_frame !== 1'b1) begin errors++; $display("FAIL frm_missing: ready=%b err=%b need 1 1", in_ready, err_frame); end
        tick();
        checks++; if (we_count !== w0 || blk_count !== 16'd3) begin errors++; $display("FAIL frm_missing_nowe: we=%0d cnt=%0d need %0d 3", we_count, blk_count, w0); end
    endtask

    task automatic test_flush();
        int w0;
        for (int k = 0; k < 6; k++) send_word(32'h300 + k, 1'b0);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL fl_err_clear: got %b need 0", err_frame); end
        send_block(32'h310);
        #1;
        checks++; if (write_en !== 1'b1 || block_out !== mk_block(32'h310)) begin errors++; $display("FAIL fl_clean_block: we=%b got %h need %h", write_en, block_out, mk_block(32'h310)); end
        tick();
        checks++; if (blk_count !== 16'd4) begin errors++; $display("FAIL fl_clean_count: got %0d need 4", blk_count); end
        dst_busy = 1'b1;
        send_block(32'h320);
        w0 = we_count;
        flush = 1'b1;
        #1;
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL fl_commit_we: got %b need 0", write_en); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || blk_count !== 16'd4 || err_frame !== 1'b0) begin errors++; $display("FAIL fl_commit_state: ready=%b cnt=%0d err=%b need 1 4 0", in_ready, blk_count, err_frame); end
        dst_busy = 1'b0;
        tick();
        tick();
        checks++; if (we_count !== w0) begin errors++; $display("FAIL fl_commit_nowe: got %0d need %0d", we_count, w0); end
        send_block(32'h330);
        flush = 1'b1;
        #1;
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL fl_idle_we: got %b need 0", write_en); end
        tick();
        flush = 1'b0;
        checks++; if (blk_count !== 16'd4 || we_count !== w0) begin errors++; $display("FAIL fl_idle_count: cnt=%0d we=%0d need 4 %0d", blk_count, we_count, w0); end
    endtask

    task automatic test_reset_mid();
        int w0;
        send_word(32'h3F0, 1'b1);
        for (int k = 0; k < 5; k++) send_word(32'h3F1 + k, 1'b0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++; if (in_ready !== 1'b1 || write_en !== 1'b0 || err_frame !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: ready=%b we=%b err=%b need 1 0 0", in_ready, write_en, err_frame); end
        checks++; if (block_out !== 416'd0 || blk_count !== 16'd0) begin errors++; $display("FAIL rmid_data: cnt=%0d block=%h need 0 0", blk_count, block_out); end
        send_block(32'h400);
        w0 = we_count;
        RST = 1'b1;
        #1;
        checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL rcommit_we: got %b need 0", write_en); end
        tick();
        RST = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || blk_count !== 16'd0 || block_out !== 416'd0 || we_count !== w0) begin errors++; $display("FAIL rcommit_state: ready=%b cnt=%0d we=%0d need 1 0 %0d", in_ready, blk_count, we_count, w0); end
    endtask

    task automatic test_wrap();
        for (int b = 0; b < 7; b++) begin
            send_block(32'h500 + 32'(b * 16));
            tick();
        end
        checks++; if (blk_count2 !== 3'd7) begin errors++; $display("FAIL wrap_pre: got %0d need 7", blk_count2); end
        send_block(32'h600);
        tick();
        checks++; if (blk_count2 !== 3'd0 || blk_count !== 16'd8) begin errors++; $display("FAIL wrap_zero: small=%0d main=%0d need 0 8", blk_count2, blk_count); end
        checks++; if (block_out2 !== block_out || err_frame2 !== err_frame || in_ready2 !== in_ready || write_en2 !== write_en) begin errors++; $display("FAIL wrap_twin: narrow instance diverged from main"); end
    endtask

    task automatic test_byte_swap();
        logic [31:0] need;
`ifdef SHA_LOADER_BYTE_SWAP_EN
        need = 32'h4433_2211;
`else
        need = 32'h1122_3344;
`endif
        send_word(32'h1122_3344, 1'b0);
        for (int k = 1; k < 13; k++) send_word(32'h700 + k, k == 12);
        #1;
        checks++; if (write_en !== 1'b1 || block_out[415:384] !== need) begin errors++; $display("FAIL swap_word0: we=%b got %h need %h", write_en, block_out[415:384], need); end
        tick();
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_last = 1'b0; flush = 1'b0; dst_busy = 1'b0; in_data = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_framing();
        test_flush();
        test_reset_mid();
        test_wrap();
        test_byte_swap();
        checks++; if (consec !== 0) begin errors++; $display("FAIL we_consecutive: got %0d need 0", consec); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha_block_loader_416.md
# sha_block_loader_416

Upstream feeder for the 416-bit SHA-256 block memory. Accepts a stream of 32-bit words over a valid/ready handshake and packs 13 of them MSB-first into a 416-bit block. Presents the completed block with a one-cycle `write_en` strobe in the format the block memory latches. Also reports framing errors and keeps a committed-block counter.

## Interface
Parameters:
- `WORD_W`, 32, input word width
- `NUM_WORDS`, 13, words per block
- `BLOCK_W`, `WORD_W*NUM_WORDS` (416), derived; do not override
- `CNT_W`, 16, width of the block counter

Ports:
- `CLK` in 1: single clock, rising edge
- `RST` in 1: reset, synchronous, active-high
- `in_valid` in 1: upstream word valid
- `in_ready` out 1: loader accepts a word this cycle
- `in_data` in `WORD_W`: word payload
- `in_last` in 1: marks the final word of a block
- `flush` in 1: discard any partial or pending block
- `dst_busy` in 1: block memory cannot take a write this cycle
- `write_en` out 1: one-cycle strobe; `block_out` is valid
- `block_out` out `BLOCK_W`: assembled block
- `blk_count` out `CNT_W`: number of blocks committed
- `err_frame` out 1: sticky framing error

## Operation
- A transfer occurs when `in_valid && in_ready`.
- `in_ready` = (state == FILL). It is registered-state only, with no combinational path from the inputs.
- FSM states:
  - **FILL**: accept words.
    - Word k (k = 0..12) is written into `block_out[BLOCK_W-1-32k -: 32]`, so word 0 lands in [415:384].
    - `wcnt` increments per transfer.
    - On the transfer with `wcnt == 12` and `in_last == 1`: go to COMMIT.
  - **COMMIT**:
    - `write_en` = `!dst_busy`.
    - When `write_en` is high: `blk_count++` (wraps modulo 2^CNT_W), clear `wcnt`, return to FILL.
    - While `dst_busy` is high: stay in COMMIT and hold `block_out`.
- Framing errors are either of these transfers:
  - `in_last == 1` with `wcnt != 12` (early last).
  - `wcnt == 12` with `in_last == 0` (missing last).
- On a framing error:
  - Set `err_frame`.
  - Clear `wcnt`.
  - Discard the partial block. No `write_en` is issued for it.
  - Stay in FILL.
- `flush`:
  - Clears `wcnt` and `err_frame`, and forces FILL.
  - A word transferred in the same cycle is dropped.
  - `flush` in COMMIT wins over commit: no `write_en`, and `blk_count` is unchanged.
- `block_out` is not cleared on commit. Stale upper words are overwritten as the next block fills.

## Timing
- Reset values:
  - state = FILL, `wcnt` = 0, `in_ready` = 1
  - `write_en` = 0, `block_out` = 0, `blk_count` = 0, `err_frame` = 0
- Reset asserted mid-block or in COMMIT: all of the above apply on the next edge, and no `write_en` is issued.
- Latency: `write_en` is high at the earliest in the cycle after the 13th transfer.
- `write_en` and `block_out` are stable together in that cycle.
- Throughput: at best one block per 14 cycles, because `in_ready` is low for at least 1 cycle in COMMIT.
- `dst_busy` is sampled only in COMMIT. It is ignored in FILL.
- `write_en` is never high for two consecutive cycles.

## Configuration
- `SHA_LOADER_BYTE_SWAP_EN` defined: each `in_data` word is byte-reversed before packing (bytes [7:0]→[31:24], and so on), for little-endian hosts.
- Not defined: words are packed unmodified.
- Framing, timing and counters are identical in both builds.

## Structure
- Shared package `sha_pkg` holds:
  - constants `SHA_WORD_W` = 32 and `SHA_BLK416_WORDS` = 13
  - the loader state enum (FILL, COMMIT)
  - `function byte_swap32`
- No sub-module is required. Optional: `sha_word_packer` (shift/index packing datapath) separate from the FSM.
- The output feeds the block memory's `write_en`/`block_in` directly.

## Test plan
1. **Basic block.**
   - Stimulus: after reset, send words 0x00000000..0x0000000C back-to-back, `in_last` on the 13th.
   - Response: `write_en` high exactly 1 cycle, the cycle after the 13th transfer. `block_out[415:384]` = 0x00000000, `block_out[31:0]` = 0x0000000C. `blk_count` = 1.
2. **Backpressure.**
   - Stimulus: hold `dst_busy` = 1 for 5 cycles in COMMIT.
   - Response: `in_ready` = 0 and `write_en` = 0 for those 5 cycles. `block_out` is unchanged. `write_en` goes high the cycle `dst_busy` falls.
3. **Framing.**
   - Stimulus A: `in_last` on word 7.
   - Response A: `err_frame` = 1, no `write_en`. The next clean 13-word block commits normally.
   - Stimulus B: 13 words with no `in_last`.
   - Response B: `err_frame` = 1, no `write_en`.
4. **Flush.**
   - Stimulus A: `flush` after 6 words.
   - Response A: the next 13 words form a clean block.
   - Stimulus B: `flush` in COMMIT with `dst_busy` = 1.
   - Response B: no `write_en`, `blk_count` unchanged, `err_frame` = 0.
5. **Reset and wrap.**
   - Stimulus A: `RST` asserted mid-block.
   - Response A: all outputs return to reset values on the next edge.
   - Stimulus B: run 65536 blocks.
   - Response B: `blk_count` wraps to 0.
6. **Byte swap.**
   - Stimulus: build with `SHA_LOADER_BYTE_SWAP_EN`, first word 0x11223344.
   - Response: `block_out[415:384]` = 0x44332211.
   - Without the macro, the same input gives 0x11223344.
